// File: rtl/alu_mdu.sv
// Execute-stage ALU with a registered result path and an iterative shift-add
// multiplier / restoring divider that writes the HI/LO registers.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_reg;
  logic               md_div, neg_q, neg_r, div0;

  // Single-cycle datapath
  logic [WIDTH-1:0]   sum_add, diff_sub, sc_result;
  logic               sc_ovf;
  logic [SHAMT_W-1:0] shamt;

  assign shamt    = alu_b[SHAMT_W-1:0];
  assign sum_add  = alu_a + alu_b;
  assign diff_sub = alu_a - alu_b;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sc_result = sum_add;
        sc_ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_add[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff_sub;
        sc_ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_sub[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_AND:  sc_result = alu_a & alu_b;
      OP_OR:   sc_result = alu_a | alu_b;
      OP_XOR:  sc_result = alu_a ^ alu_b;
      OP_NOR:  sc_result = ~(alu_a | alu_b);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      OP_SLL:  sc_result = alu_a << shamt;
      OP_SRL:  sc_result = alu_a >> shamt;
      OP_SRA:  sc_result = $signed(alu_a) >>> shamt;
      OP_MFHI: sc_result = hi;
      OP_MFLO: sc_result = lo;
      default: sc_result = '0;
    endcase
  end

  // Operand preparation for MULT/MULTU/DIV/DIVU (opcodes 12..15)
  logic             is_md_op, is_signed, is_div_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_md_op  = (alu_op[4:2] == 3'b011);
  assign is_signed = ~alu_op[0];
  assign is_div_op = alu_op[1];
  assign mag_a     = (is_signed && alu_a[WIDTH-1]) ? -alu_a : alu_a;
  assign mag_b     = (is_signed && alu_b[WIDTH-1]) ? -alu_b : alu_b;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_step  = {mul_sum, acc[WIDTH-1:1]};
  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opd};
  assign div_step  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up and special cases applied when leaving FIN
  logic [WIDTH-1:0] fin_hi, fin_lo;

  always_comb begin
    fin_hi = '0;
    fin_lo = '0;
    if (md_div) begin
      if (div0) begin
        fin_lo = '1;
        fin_hi = a_reg;
      end else begin
        fin_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fin_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end else begin
      {fin_hi, fin_lo} = neg_q ? -acc : acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       if (start && is_md_op) state_n = is_div_op ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt == CNT_W'(1)) state_n = S_FIN;
      S_FIN:        state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      opd     <= '0;
      a_reg   <= '0;
      md_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && is_md_op) begin
            cnt    <= CNT_W'(WIDTH);
            acc    <= {{WIDTH{1'b0}}, is_div_op ? mag_a : mag_b};
            opd    <= is_div_op ? mag_b : mag_a;
            a_reg  <= alu_a;
            md_div <= is_div_op;
            neg_q  <= is_signed && (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]);
            neg_r  <= is_signed && alu_a[WIDTH-1];
            div0   <= (alu_b == '0);
          end else if (start) begin
            alu_out <= sc_result;
            zero    <= (sc_result == '0);
            ovf     <= sc_ovf;
            done    <= 1'b1;
          end
        end
        S_MUL: begin
          acc <= mul_step;
          cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          acc <= div_step;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIN: begin
          hi      <= fin_hi;
          lo      <= fin_lo;
          alu_out <= fin_lo;
          zero    <= (fin_lo == '0);
          ovf     <= 1'b0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboarded bench for alu_mdu: stimulus pushes model results, a monitor
// pops and compares on every done pulse.
module tb_alu_mdu;

  localparam int W = 32;
  localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, SUB = 5'd2, SLT = 5'd7, SLTU = 5'd8,
                         SRL = 5'd10, SRA = 5'd11, MULT = 5'd12, MULTU = 5'd13,
                         DIV = 5'd14, DIVU = 5'd15, MFHI = 5'd16, MFLO = 5'd17;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   alu_op = '0;
  logic [W-1:0] alu_a = '0, alu_b = '0;
  logic [W-1:0] alu_out, hi, lo;
  logic         zero, ovf, busy, done;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .zero(zero), .ovf(ovf), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb_, s, q, r;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    sh = int'(b[4:0]);
    e.out = '0;
    e.ovf = 1'b0;
    case (op)
      1:  begin s = sa + sb_; e.out = a + b; e.ovf = (s > SMAX) || (s < SMIN); end
      2:  begin s = sa - sb_; e.out = a - b; e.ovf = (s > SMAX) || (s < SMIN); end
      3:  e.out = a & b;
      4:  e.out = a | b;
      5:  e.out = a ^ b;
      6:  e.out = ~(a | b);
      7:  e.out = (sa < sb_) ? 1 : 0;
      8:  e.out = (a < b) ? 1 : 0;
      9:  e.out = a << sh;
      10: e.out = a >> sh;
      11: e.out = $signed(a) >>> sh;
      12: begin p = sa * sb_; {m_hi, m_lo} = p; e.out = m_lo; end
      13: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; e.out = m_lo; end
      14: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == '1) begin m_lo = a; m_hi = '0; end
        else begin q = sa / sb_; r = sa % sb_; m_lo = q[31:0]; m_hi = r[31:0]; end
        e.out = m_lo;
      end
      15: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        e.out = m_lo;
      end
      16: e.out = m_hi;
      17: e.out = m_lo;
      default: e.out = '0;
    endcase
    e.zero = (e.out == '0);
    e.hi = m_hi;
    e.lo = m_lo;
    return e;
  endfunction

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_out", alu_out, e.out);
        check("zero", zero, e.zero);
        check("ovf", ovf, e.ovf);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
      end
    end
  end

  // Single-cycle issue; start is left high so callers can chain back-to-back ops.
  task automatic do_sc(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(op, a, b));
    alu_op = op; alu_a = a; alu_b = b; start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_md(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold);
    int j;
    sb.push_back(model(op, a, b));
    alu_op = op; alu_a = a; alu_b = b; start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin alu_op = ADD; alu_a = $urandom; alu_b = $urandom; end
    else start = 1'b0;
    j = 0;
    while (!done && j <= 2 * W) begin
      if (j == 0 || j == W) check("busy_during", busy, 1);
      if (j == W) start = 1'b0;
      @(posedge clk); #1;
      j++;
    end
    check("md_latency", j, W + 1);
    check("busy_after", busy, 0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int j;
    logic [4:0] op;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_out", alu_out, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed single-cycle ops, issued back to back
    do_sc(ADD, 32'h7FFF_FFFF, 32'h1);
    do_sc(SUB, 32'd5, 32'd5);
    do_sc(SLT, 32'hFFFF_FFFF, 32'h1);
    do_sc(SLTU, 32'hFFFF_FFFF, 32'h1);
    do_sc(SRA, 32'h8000_0000, 32'h24);
    do_sc(SRL, 32'h8000_0000, 32'h24);
    idle(2);
    check("done_drops", done, 0);

    // Directed multiply/divide
    do_md(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_md(MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_md(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_md(DIVU, 32'd7, 32'd0, 1'b0);
    do_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_md(DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);

    // start/ADD held while busy, then MFLO/MFHI right on the done cycle
    do_md(MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    do_sc(MFLO, 32'h0, 32'h0);
    do_sc(MFHI, 32'h0, 32'h0);
    idle(1);

    // Reset ten cycles into a DIV
    sb.push_back(model(DIV, 32'd1000, 32'd3));
    alu_op = DIV; alu_a = 32'd1000; alu_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (j = 0; j < 10; j++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_done", done, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_md(DIVU, 32'd100, 32'd7, 1'b0);
    do_sc(MFHI, 32'h0, 32'h0);
    idle(1);

    // Randomized mix of all opcodes
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= MULT && op <= DIVU) do_md(op, rand_opnd(), rand_opnd(), ($urandom_range(0, 1) == 1));
      else do_sc(op, rand_opnd(), rand_opnd());
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
